qenc_sampler: RTL and testbench

//   Controller for the quadrature encoder interface (qencoder). Gates its enable, samples
//   its position output at a programmable fixed period and computes the signed position

---
 rtl/qenc_sampler.sv | 177 +++++++++++++++++
 tb/tb_qenc_sampler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qenc_sampler.sv
// ---------------------------------------------------------------------------
// qenc_sampler
//
// Purpose:
//   Controller for the quadrature encoder block. It gates the encoder
//   enable, samples the encoder position once every programmable period
//   and computes the signed position change over that period (a velocity
//   estimate). Each sample is offered to a downstream consumer on a
//   valid/ready handshake.
//
// Ports:
//   clk             system clock
//   i_reset         synchronous reset, active-high
//   i_enable        run request: 1 = arm and sample, 0 = stop
//   i_period        sample period P in clk cycles (0 never starts a run)
//   i_position      encoder position
//   i_dir           encoder direction
//   o_qenc_enable   encoder enable (high in ARM and RUN)
//   o_sample_pos    position captured at the sample tick
//   o_sample_delta  position change since the previous tick (two's complement)
//   o_sample_dir    direction captured at the sample tick
//   o_valid         a sample is being offered
//   i_ready         consumer accepts the offered sample
//   o_overrun       sticky: an unaccepted sample was overwritten
//   o_state         FSM state (IDLE=00, ARM=01, RUN=10, DRAIN=11)
//
// Handshake: a sample transfers in any cycle where o_valid && i_ready are
// both high at the clock edge. o_valid drops after a transfer unless a new
// tick loads a fresh sample in the same cycle. While o_valid && !i_ready the
// sample data is held, except when a tick overwrites it, which sets
// o_overrun until reset or the next ARM.
// ---------------------------------------------------------------------------
module qenc_sampler #(
  parameter int NB     = 32,
  parameter int NB_DIV = 24
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NB_DIV-1:0] i_period,
  input  logic [NB-1:0]     i_position,
  input  logic              i_dir,
  output logic              o_qenc_enable,
  output logic [NB-1:0]     o_sample_pos,
  output logic [NB-1:0]     o_sample_delta,
  output logic              o_sample_dir,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARM   = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [NB_DIV-1:0] CNT_ONE = NB_DIV'(1);

  state_t            state;
  state_t            state_next;
  logic [NB_DIV-1:0] cnt;
  logic [NB_DIV-1:0] period_r;
  logic [NB-1:0]     prev_pos;
  logic              tick;
  logic              xfer;

  assign o_state = state;
  assign xfer    = o_valid && i_ready;

  // -------------------------------------------------------------------------
  // Next-state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    tick          = 1'b0;
    o_qenc_enable = 1'b0;

    case (state)
      IDLE: begin
        // A zero period would never tick, so it is refused here.
        if (i_enable && (i_period != '0)) begin
          state_next = ARM;
        end
      end

      ARM: begin
        o_qenc_enable = 1'b1;
        state_next    = RUN;
      end

      RUN: begin
        o_qenc_enable = 1'b1;
        // Stopping takes priority: the cycle that sees i_enable low never
        // produces a tick, even if the counter has expired.
        if (!i_enable) begin
          state_next = DRAIN;
        end else if (cnt == '0) begin
          tick = 1'b1;
        end
      end

      DRAIN: begin
        // Encoder is already gated off; wait for the last sample to go.
        if (!o_valid) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      period_r       <= '0;
      prev_pos       <= '0;
      o_sample_pos   <= '0;
      o_sample_delta <= '0;
      o_sample_dir   <= 1'b0;
      o_valid        <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      state <= state_next;

      case (state)
        ARM: begin
          // Period is latched here so later i_period changes only take
          // effect on the next arm. Loading P-1 places the first tick
          // exactly P cycles after this ARM cycle.
          period_r  <= i_period;
          cnt       <= i_period - CNT_ONE;
          prev_pos  <= i_position;
          o_overrun <= 1'b0;
        end

        RUN: begin
          if (i_enable) begin
            if (tick) begin
              cnt <= period_r - CNT_ONE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end

        default: begin
        end
      endcase

      if (tick) begin
        // Modular subtraction gives the correct signed delta across the
        // position wrap as long as motion per period stays under 2^(NB-1).
        o_sample_pos   <= i_position;
        o_sample_delta <= i_position - prev_pos;
        o_sample_dir   <= i_dir;
        prev_pos       <= i_position;
        o_valid        <= 1'b1;
        if (o_valid && !i_ready) begin
          o_overrun <= 1'b1;
        end
      end else if (xfer) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qenc_sampler.sv
`timescale 1ns/1ps
module tb_qenc_sampler;

  localparam int NB     = 32;
  localparam int NB_DIV = 24;
  localparam int EW     = 32 + NB + NB + 1;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_enable = 1'b0;
  logic [NB_DIV-1:0] i_period = '0;
  logic [NB-1:0]     i_position = '0;
  logic              i_dir = 1'b0;
  logic              i_ready = 1'b0;
  logic              o_qenc_enable;
  logic [NB-1:0]     o_sample_pos;
  logic [NB-1:0]     o_sample_delta;
  logic              o_sample_dir;
  logic              o_valid;
  logic              o_overrun;
  logic [1:0]        o_state;

  always #5 clk = ~clk;

  int cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  qenc_sampler #(.NB(NB), .NB_DIV(NB_DIV)) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_period       (i_period),
    .i_position     (i_position),
    .i_dir          (i_dir),
    .o_qenc_enable  (o_qenc_enable),
    .o_sample_pos   (o_sample_pos),
    .o_sample_delta (o_sample_delta),
    .o_sample_dir   (o_sample_dir),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_overrun      (o_overrun),
    .o_state        (o_state)
  );

  // ---------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [NB-1:0] act,
                     input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_state != 2'b00 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (o_state != 2'b00) begin
      errors++;
      $display("FAIL %s timeout actual_state=%0d required_state=0", name, o_state);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard: entries are {arrival cycle, pos, delta, dir}
  // ---------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  logic          sb_en = 1'b0;
  logic [EW-1:0] sb_got;
  logic [EW-1:0] sb_exp;

  always @(negedge clk) begin
    if (sb_en && o_valid && i_ready) begin
      checks++;
      sb_got = {32'(cycle_n), o_sample_pos, o_sample_delta, o_sample_dir};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none", sb_got);
      end else begin
        sb_exp = exp_q.pop_front();
        if (sb_got !== sb_exp) begin
          errors++;
          $display("FAIL sb_sample actual=%h required=%h", sb_got, sb_exp);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Vector table for delta arithmetic across the wrap
  // ---------------------------------------------------------------------
  typedef struct {
    logic [NB-1:0] pos_a;
    logic [NB-1:0] pos_b;
    logic          dir;
    logic [NB-1:0] delta;
  } vec_t;

  vec_t vecs[6];

  logic [NB-1:0] pos_v;
  logic [NB-1:0] last_v;
  logic          dir_v;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'h0000_0005};
    vecs[1] = '{32'h0000_0003, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFB};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0002};
    vecs[3] = '{32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h1234_5678, 32'h1234_5600, 1'b0, 32'hFFFF_FF88};

    // 1: reset for three cycles
    i_reset = 1'b1;
    i_enable = 1'b0;
    repeat (3) cyc();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_qen", 32'(o_qenc_enable), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    chk("rst_pos", o_sample_pos, 32'd0);
    chk("rst_delta", o_sample_delta, 32'd0);
    chk("rst_dir", 32'(o_sample_dir), 32'd0);
    i_reset = 1'b0;
    cyc();
    chk("idle_hold", 32'(o_state), 32'd0);

    // 2: P=10, always ready, position +1 every 4 cycles, random direction
    sb_en = 1'b1;
    i_ready = 1'b1;
    i_period = 24'd10;
    last_v = '0;
    for (int j = 0; j <= 52; j++) begin
      pos_v = 32'h0000_1000 + 32'(j / 4);
      dir_v = 1'($urandom_range(0, 1));
      i_position = pos_v;
      i_dir = dir_v;
      i_enable = (j < 52);
      if (j == 1) last_v = pos_v;
      if (j > 1 && ((j - 1) % 10) == 0) begin
        exp_q.push_back({32'(cycle_n + 1), pos_v, pos_v - last_v, dir_v});
        last_v = pos_v;
      end
      cyc();
    end
    wait_idle("run10_idle");
    chk("run10_queue_empty", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b0;

    // 3: P=5, consumer stalls for 12 cycles after the first valid
    i_period = 24'd5;
    i_dir = 1'b0;
    for (int j = 0; j <= 22; j++) begin
      if (j == 7) begin
        chk("ovr_first_valid", 32'(o_valid), 32'd1);
        chk("ovr_first_pos", o_sample_pos, 32'd106);
        chk("ovr_first_delta", o_sample_delta, 32'd5);
        chk("ovr_first_flag", 32'(o_overrun), 32'd0);
      end
      if (j == 11) begin
        chk("ovr_hold_pos", o_sample_pos, 32'd106);
        chk("ovr_hold_flag", 32'(o_overrun), 32'd0);
      end
      if (j == 12) begin
        chk("ovr_set_flag", 32'(o_overrun), 32'd1);
        chk("ovr_new_pos", o_sample_pos, 32'd111);
        chk("ovr_new_delta", o_sample_delta, 32'd5);
      end
      if (j == 17) chk("ovr_newest_pos", o_sample_pos, 32'd116);
      if (j == 20) begin
        chk("ovr_xfer_drop", 32'(o_valid), 32'd0);
        chk("ovr_sticky", 32'(o_overrun), 32'd1);
      end
      if (j == 22) begin
        chk("ovr_next_valid", 32'(o_valid), 32'd1);
        chk("ovr_next_pos", o_sample_pos, 32'd121);
      end
      i_position = 32'(100 + j);
      i_ready = !(j >= 7 && j <= 18);
      i_enable = (j < 22);
      cyc();
    end
    wait_idle("ovr_idle");
    chk("ovr_sticky_idle", 32'(o_overrun), 32'd1);

    // 4: table of wrap / reverse / half-range deltas, P=2
    i_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      i_period = 24'd2;
      i_enable = 1'b1;
      i_position = vecs[v].pos_a;
      cyc();
      chk("tbl_arm_state", 32'(o_state), 32'd1);
      chk("tbl_arm_qen", 32'(o_qenc_enable), 32'd1);
      cyc();
      i_position = vecs[v].pos_b;
      i_dir = vecs[v].dir;
      cyc();
      cyc();
      chk("tbl_pos", o_sample_pos, vecs[v].pos_b);
      chk("tbl_delta", o_sample_delta, vecs[v].delta);
      chk("tbl_dir", 32'(o_sample_dir), 32'(vecs[v].dir));
      chk("tbl_overrun_clear", 32'(o_overrun), 32'd0);
      i_enable = 1'b0;
      cyc();
      wait_idle("tbl_idle");
    end

    // 5: stop with a sample pending, then a zero period
    i_period = 24'd3;
    i_ready = 1'b0;
    i_position = 32'h0000_0A00;
    i_enable = 1'b1;
    repeat (5) cyc();
    chk("drn_valid_before", 32'(o_valid), 32'd1);
    i_enable = 1'b0;
    cyc();
    chk("drn_state", 32'(o_state), 32'd3);
    chk("drn_qen", 32'(o_qenc_enable), 32'd0);
    chk("drn_valid_held", 32'(o_valid), 32'd1);
    cyc();
    chk("drn_still", 32'(o_state), 32'd3);
    chk("drn_pos_stable", o_sample_pos, 32'h0000_0A00);
    i_ready = 1'b1;
    cyc();
    chk("drn_xfer_drop", 32'(o_valid), 32'd0);
    cyc();
    chk("drn_to_idle", 32'(o_state), 32'd0);
    i_period = '0;
    i_enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("zero_period_idle", 32'(o_state), 32'd0);
      chk("zero_period_qen", 32'(o_qenc_enable), 32'd0);
    end

    // 6: reset while running with a pending overrun sample
    i_period = 24'd2;
    i_ready = 1'b0;
    i_position = 32'h0000_0055;
    i_enable = 1'b1;
    repeat (6) cyc();
    chk("rrun_state", 32'(o_state), 32'd2);
    chk("rrun_valid", 32'(o_valid), 32'd1);
    chk("rrun_overrun", 32'(o_overrun), 32'd1);
    i_reset = 1'b1;
    cyc();
    chk("rrun_to_idle", 32'(o_state), 32'd0);
    chk("rrun_valid_clr", 32'(o_valid), 32'd0);
    chk("rrun_overrun_clr", 32'(o_overrun), 32'd0);
    chk("rrun_pos_clr", o_sample_pos, 32'd0);
    chk("rrun_qen", 32'(o_qenc_enable), 32'd0);
    i_reset = 1'b0;
    i_enable = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
